// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers for the round sequencer.
package aes_pkg;

  // State dimension (rows per column and number of columns) and cipher round count.
  localparam int N  = 4;
  localparam int NR = 10;

  // Round count in the 4-bit width used by the sequencer's counter and key index.
  localparam logic [3:0] NR_CNT = 4'd10;

  // One AES block. Element [c][r] is column c, row r, which is byte 4c+r of the block.
  typedef logic [N-1:0][N-1:0][7:0] state_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Forward S-box. Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // SubBytes substitution of a single byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  state_t i_state,
  input  state_t i_round_key,
  input  logic   i_last,
  output state_t o_state
);

  state_t w_sub;
  state_t w_shift;
  state_t w_mix;

  // SubBytes then ShiftRows: row r rotates left by r columns.
  for (genvar c = 0; c < N; c++) begin : g_col
    for (genvar r = 0; r < N; r++) begin : g_row
      assign w_sub[c][r]   = sbox(i_state[c][r]);
      assign w_shift[c][r] = w_sub[(c + r) % N][r];
    end
  end

  mix_columns u_mix_columns (
    .i_state (w_shift),
    .o_state (w_mix)
  );

  // The final round omits MixColumns before the key addition.
  assign o_state = (i_last ? w_shift : w_mix) ^ i_round_key;

endmodule

// File: rtl/mix_columns.sv
// Combinational MixColumns: each column is multiplied by the fixed AES circulant matrix.
module mix_columns
  import aes_pkg::*;
(
  input  state_t i_state,
  output state_t o_state
);

  // Row r of a column gets 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3], indices taken modulo N.
  for (genvar c = 0; c < N; c++) begin : g_col
    for (genvar r = 0; r < N; r++) begin : g_row
      assign o_state[c][r] = xtime(i_state[c][r])
                           ^ xtime(i_state[c][(r + 1) % N]) ^ i_state[c][(r + 1) % N]
                           ^ i_state[c][(r + 2) % N]
                           ^ i_state[c][(r + 3) % N];
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: initial key addition on accept, then one round per clock.
module aes_round_sequencer
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     in_state,
  output logic [3:0] key_idx,
  input  state_t     round_key,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     out_state,
  output logic       busy
);

  fsm_t       r_fsm;
  logic [3:0] r_round_cnt;
  state_t     r_state;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       r_busy;
  logic [3:0] r_key_idx;

  state_t     w_round_state;
  logic       w_last;

  assign w_last = (r_round_cnt == NR_CNT);

  aes_round u_aes_round (
    .i_state     (r_state),
    .i_round_key (round_key),
    .i_last      (w_last),
    .o_state     (w_round_state)
  );

  // Control FSM; key_idx is registered one step ahead so it always equals the round about to be applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_round_cnt <= 4'd0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_key_idx   <= 4'd0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_state     <= in_state ^ round_key;
            r_round_cnt <= 4'd1;
            r_key_idx   <= 4'd1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_fsm       <= ROUND;
          end
        end
        ROUND: begin
          r_state <= w_round_state;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_key_idx   <= 4'd0;
            r_fsm       <= DONE;
          end else begin
            r_round_cnt <= r_round_cnt + 4'd1;
            r_key_idx   <= r_round_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_round_cnt <= 4'd0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_fsm       <= IDLE;
          end
        end
        default: begin
          r_round_cnt <= 4'd0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_key_idx   <= 4'd0;
          r_fsm       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign key_idx   = r_key_idx;
  assign out_state = r_state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer using the FIPS-197 example vectors.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  state_t     in_state;
  logic [3:0] key_idx;
  state_t     round_key;
  logic       out_valid;
  logic       out_ready;
  state_t     out_state;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ks = 0;
  logic [127:0] rk [0:1][0:10];
  logic [127:0] exp_q [$];

  aes_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block hex string (byte 0 first) to column-major state and back.
  function automatic state_t to_state(input logic [127:0] h);
    state_t s;
    for (int k = 0; k < 16; k++) s[k / 4][k % 4] = h[127 - 8 * k -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] h;
    for (int k = 0; k < 16; k++) h[127 - 8 * k -: 8] = s[k / 4][k % 4];
    return h;
  endfunction

  // Key-schedule store model: answers key_idx combinationally from the selected key set.
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = to_state(rk[ks][key_idx]);
  end

  // AES-128 key expansion into key set s.
  task automatic expand(input int s, input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[s][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With in_valid held high, step to the accept edge and return its cycle number.
  task automatic wait_accept(output int t);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=in_ready_low expected=in_ready_high");
    end else begin
      tick();
    end
    t = cyc;
  endtask

  task automatic wait_out_valid(output int t);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got=0 expected=1");
    end
    t = cyc;
  endtask

  // Monitor: every completed output handshake must match the oldest expected ciphertext.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h expected=none", from_state(out_state));
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (from_state(out_state) !== e) begin
          errors++;
          $display("FAIL ciphertext got=%h expected=%h", from_state(out_state), e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = '0;
    expand(0, KEY_B);
    expand(1, KEY_C);
    ks = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_key_idx", key_idx, 0);
    check("rst_out_state", from_state(out_state), 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Appendix B vector and accept-to-out_valid latency.
    ks = 0; out_ready = 1'b1; in_state = to_state(PT_B); in_valid = 1'b1;
    wait_accept(t0);
    in_valid = 1'b0;
    exp_q.push_back(CT_B);
    check("b_busy", busy, 1);
    check("b_in_ready_low", in_ready, 0);
    wait_out_valid(t1);
    check("b_latency", t1 - t0, 10);
    tick();
    check("b_in_ready_back", in_ready, 1);

    // Appendix C.1 vector and the key index walk 0..10.
    ks = 1; in_state = to_state(PT_C); in_valid = 1'b1;
    check("c_in_ready", in_ready, 1);
    check("c_key_idx_0", key_idx, 0);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(CT_C);
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("c_key_idx_%0d", k), key_idx, k);
      tick();
    end
    check("c_out_valid", out_valid, 1);
    check("c_key_idx_done", key_idx, 0);
    tick();

    // Backpressure: result held stable for 20 cycles, then released.
    ks = 0; out_ready = 1'b0; in_state = to_state(PT_B); in_valid = 1'b1;
    wait_accept(t0);
    in_valid = 1'b0;
    exp_q.push_back(CT_B);
    wait_out_valid(t1);
    for (int k = 0; k < 20; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_state", from_state(out_state), CT_B);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_busy", busy, 0);

    // in_valid pulsed mid-computation must be ignored.
    ks = 1; in_state = to_state(PT_C); in_valid = 1'b1;
    wait_accept(t0);
    in_valid = 1'b0;
    exp_q.push_back(CT_C);
    repeat (3) tick();
    in_state = to_state(PT_B); in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    wait_out_valid(t1);
    check("pulse_latency", t1 - t0, 10);
    tick();
    for (int k = 0; k < 12; k++) begin
      check("pulse_no_extra_output", out_valid, 0);
      tick();
    end

    // Back-to-back blocks with in_valid and out_ready held high.
    ks = 0; in_state = to_state(PT_B); in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(t1);
    exp_q.push_back(CT_B);
    in_state = to_state(PT_C);
    wait_out_valid(t0);
    ks = 1;
    wait_accept(t2);
    in_valid = 1'b0;
    exp_q.push_back(CT_C);
    check("b2b_accept_spacing", t2 - t1, 12);
    wait_out_valid(t0);
    tick();

    // Reset at round 5 discards the block; a fresh block then encrypts correctly.
    ks = 0; in_state = to_state(PT_B); in_valid = 1'b1;
    wait_accept(t0);
    in_valid = 1'b0;
    exp_q.push_back(CT_B);
    repeat (4) tick();
    check("mr_key_idx_5", key_idx, 5);
    rst_n = 1'b0;
    #1;
    check("mr_in_ready", in_ready, 1);
    check("mr_out_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_key_idx", key_idx, 0);
    check("mr_out_state", from_state(out_state), 0);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    ks = 1; in_state = to_state(PT_C); in_valid = 1'b1;
    wait_accept(t0);
    in_valid = 1'b0;
    exp_q.push_back(CT_C);
    wait_out_valid(t1);
    check("mr_after_latency", t1 - t0, 10);
    tick();

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
